// File: rtl/bist_frame_sequencer.sv
// Built-in-self-test frame sequencer: clears the signature analyzer, streams FRAME_PX
// LFSR pixels through the pipeline, waits for the drain, then checks the signature.
module bist_frame_sequencer #(
  parameter int FRAME_PX  = 64,
  parameter int DRAIN_MAX = 32,
  parameter int SIG_W     = 24
) (
  input  logic             clk_i,
  input  logic             reset_i,
  input  logic             start_i,
  input  logic             abort_i,
  input  logic [1:0]       mode_i,
  input  logic [SIG_W-1:0] golden_sig_i,
  input  logic             lfsr_rdy_i,
  input  logic             px_rdy_i,
  input  logic [SIG_W-1:0] sa_sig_i,
  output logic [1:0]       select_o,
  output logic             start_sobel_o,
  output logic             lfsr_en_o,
  output logic             sa_clear_o,
  output logic             sa_en_o,
  output logic             busy_o,
  output logic             done_o,
  output logic             pass_o,
  output logic             timeout_o
);

  localparam int CW = $clog2(FRAME_PX + 1);
  localparam int WW = $clog2(DRAIN_MAX + 1);

  localparam logic [CW-1:0] C_FRAME   = CW'(FRAME_PX);
  localparam logic [CW-1:0] C_LAST_PX = CW'(FRAME_PX - 1);
  localparam logic [WW-1:0] C_WD_LAST = WW'(DRAIN_MAX - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLEAR,
    S_RUN,
    S_DRAIN,
    S_CHECK,
    S_DONE
  } state_t;

  state_t             r_state;
  state_t             w_next;
  logic [1:0]         r_mode;
  logic [SIG_W-1:0]   r_golden;
  logic [CW-1:0]      r_in_cnt;
  logic [CW-1:0]      r_out_cnt;
  logic [WW-1:0]      r_wdog;
  logic               r_pass;
  logic               r_timeout;

  logic               w_out_inc;
  logic               w_out_done;
  logic               w_wd_expired;
  logic               w_last_in;

  // The output count saturates, so completion is "already full" or "this pulse fills it".
  assign w_out_inc    = px_rdy_i && (r_out_cnt != C_FRAME);
  assign w_out_done   = (r_out_cnt == C_FRAME) || (px_rdy_i && (r_out_cnt == C_LAST_PX));
  assign w_wd_expired = (r_wdog == C_WD_LAST);
  assign w_last_in    = lfsr_rdy_i && (r_in_cnt == C_LAST_PX);

  // NOTE: w_next gets its default before the case so no path leaves it unassigned,
  // which would otherwise infer a latch.
  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE,
      S_DONE:  if (start_i) w_next = S_CLEAR;
      S_CLEAR: w_next = S_RUN;
      S_RUN:   if (w_last_in) w_next = S_DRAIN;
      S_DRAIN: begin
        if (w_out_done)        w_next = S_CHECK;
        else if (w_wd_expired) w_next = S_DONE;
      end
      S_CHECK: w_next = S_DONE;
      default: w_next = S_IDLE;
    endcase
    if (abort_i) w_next = S_IDLE;
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples
  // the pre-edge values of its neighbours, independent of statement order.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      r_state   <= S_IDLE;
      r_mode    <= '0;
      r_golden  <= '0;
      r_in_cnt  <= '0;
      r_out_cnt <= '0;
      r_wdog    <= '0;
      r_pass    <= 1'b0;
      r_timeout <= 1'b0;
    end else begin
      r_state <= w_next;
      if (abort_i) begin
        r_mode    <= '0;
        r_golden  <= '0;
        r_in_cnt  <= '0;
        r_out_cnt <= '0;
        r_wdog    <= '0;
        r_pass    <= 1'b0;
        r_timeout <= 1'b0;
      end else begin
        unique case (r_state)
          S_IDLE,
          S_DONE: begin
            if (start_i) begin
              r_mode    <= mode_i;
              r_golden  <= golden_sig_i;
              r_in_cnt  <= '0;
              r_out_cnt <= '0;
              r_wdog    <= '0;
              r_pass    <= 1'b0;
              r_timeout <= 1'b0;
            end
          end
          S_RUN: begin
            if (lfsr_rdy_i) r_in_cnt <= r_in_cnt + CW'(1);
            if (w_out_inc)  r_out_cnt <= r_out_cnt + CW'(1);
          end
          S_DRAIN: begin
            if (w_out_inc) r_out_cnt <= r_out_cnt + CW'(1);
            if (!w_out_done) begin
              if (w_wd_expired) begin
                r_timeout <= 1'b1;
                r_pass    <= 1'b0;
              end else begin
                r_wdog <= r_wdog + WW'(1);
              end
            end
          end
          S_CHECK: r_pass <= (sa_sig_i == r_golden);
          default: ;
        endcase
      end
    end
  end

  assign select_o      = r_mode;
  assign start_sobel_o = (r_state == S_RUN) || (r_state == S_DRAIN);
  assign lfsr_en_o     = (r_state == S_RUN);
  assign sa_clear_o    = (r_state == S_CLEAR);
  assign busy_o        = (r_state == S_CLEAR) || (r_state == S_RUN) ||
                         (r_state == S_DRAIN) || (r_state == S_CHECK);
  assign sa_en_o       = busy_o;
  assign done_o        = (r_state == S_DONE);
  assign pass_o        = r_pass;
  assign timeout_o     = r_timeout;

endmodule
